// File: rtl/k12a_io_pkg.sv
// Shared K12A I/O bus definitions: GPIO register offsets and the address-width helper.
// Imported by the bank, its ports and the bus interface.
package k12a_io_pkg;

    localparam logic [2:0] GPIO_OUT     = 3'd0;
    localparam logic [2:0] GPIO_DIR     = 3'd1;
    localparam logic [2:0] GPIO_IN      = 3'd2;
    localparam logic [2:0] GPIO_RISE_EN = 3'd3;
    localparam logic [2:0] GPIO_FALL_EN = 3'd4;
    localparam logic [2:0] GPIO_PEND    = 3'd5;
    localparam logic [2:0] GPIO_SET     = 3'd6;
    localparam logic [2:0] GPIO_CLR     = 3'd7;

    // Port index field is at least one bit wide so a single-port bank still rejects index 1.
    function automatic int gpio_addr_w(input int num_ports);
        return ((num_ports > 1) ? $clog2(num_ports) : 1) + 3;
    endfunction

endpackage

// File: rtl/k12a_gpio_bank_if.sv
// K12A I/O bus control strobes and address; the tristate data bus stays a plain inout.
// Strobes are active-low; no backpressure, every access completes in one cycle.
interface k12a_gpio_bank_if #(
    parameter int ADDR_W = 5
);
    logic              io_load_n;
    logic              io_store_n;
    logic [ADDR_W-1:0] io_addr;

    modport master (output io_load_n, output io_store_n, output io_addr);
    modport slave  (input  io_load_n, input  io_store_n, input  io_addr);
endinterface

// File: rtl/k12a_gpio_port.sv
// One GPIO port: OUT/DIR/enable registers, input synchroniser, edge detect into W1C pending flags.
// Writes land on the sampling edge; reads are combinational; no wait states or backpressure.
module k12a_gpio_port
    import k12a_io_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sel,
    input  logic              load,
    input  logic              store,
    input  logic [2:0]        reg_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic [DATA_W-1:0] pin_in,
    output logic [DATA_W-1:0] rd_dat,
    output logic              rd_vld,
    output logic [DATA_W-1:0] out_dat,
    output logic [DATA_W-1:0] oe_dat,
    output logic [DATA_W-1:0] pend_dat
);

    logic [DATA_W-1:0] out_q, out_d, dir_q, dir_d;
    logic [DATA_W-1:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [DATA_W-1:0] pend_q, pend_d, prev_q, prev_d;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q, sync_d;
    logic [DATA_W-1:0] in_s, rise, fall, w1c;
    logic              wr;

    always_comb begin
        wr        = sel & store;
        in_s      = sync_q[SYNC_STAGES-1];
        rise      = in_s & ~prev_q;
        fall      = ~in_s & prev_q;
        sync_d    = {sync_q[SYNC_STAGES-2:0], pin_in};
        prev_d    = in_s;
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (wr) begin
            case (reg_addr)
                GPIO_OUT:     out_d     = wr_dat;
                GPIO_DIR:     dir_d     = wr_dat;
                GPIO_RISE_EN: rise_en_d = wr_dat;
                GPIO_FALL_EN: fall_en_d = wr_dat;
                GPIO_PEND:    w1c       = wr_dat;
                GPIO_SET:     out_d     = out_q | wr_dat;
                GPIO_CLR:     out_d     = out_q & ~wr_dat;
                default:      ;
            endcase
        end
        // Old enables gate the edges, and a new edge outranks a same-cycle clear.
        pend_d = (pend_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);

        rd_vld = sel & load;
        case (reg_addr)
            GPIO_OUT:     rd_dat = out_q;
            GPIO_DIR:     rd_dat = dir_q;
            GPIO_IN:      rd_dat = in_s;
            GPIO_RISE_EN: rd_dat = rise_en_q;
            GPIO_FALL_EN: rd_dat = fall_en_q;
            GPIO_PEND:    rd_dat = pend_q;
            default:      rd_dat = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
            prev_q    <= '0;
            sync_q    <= '0;
        end else begin
            out_q     <= out_d;
            dir_q     <= dir_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            pend_q    <= pend_d;
            prev_q    <= prev_d;
            sync_q    <= sync_d;
        end
    end

    assign out_dat  = out_q;
    assign oe_dat   = dir_q;
    assign pend_dat = pend_q;

endmodule

// File: rtl/k12a_gpio_bank.sv
// NUM_PORTS GPIO ports on the K12A I/O bus; combinational readback onto the tristate bus, wake = OR of pending.
// Single-cycle accesses, no backpressure; the bus is driven only on a pure read of an existing port.
module k12a_gpio_bank
    import k12a_io_pkg::*;
#(
    parameter int NUM_PORTS   = 3,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    k12a_gpio_bank_if.slave               io,
    inout  wire  [DATA_W-1:0]             data_bus,
    output logic [NUM_PORTS*DATA_W-1:0]   gpio_out,
    output logic [NUM_PORTS*DATA_W-1:0]   gpio_oe,
    input  logic [NUM_PORTS*DATA_W-1:0]   gpio_in,
    output logic                          wake
);

    localparam int ADDR_W = gpio_addr_w(NUM_PORTS);
    localparam int PORT_W = ADDR_W - 3;

    logic                             load, store, any_vld;
    logic [PORT_W-1:0]                port_idx;
    logic [NUM_PORTS-1:0]             rd_vld;
    logic [NUM_PORTS-1:0][DATA_W-1:0] rd_dat, pend_dat;
    logic [DATA_W-1:0]                rd_any;

    assign load     = ~io.io_load_n;
    assign store    = ~io.io_store_n;
    assign port_idx = io.io_addr[ADDR_W-1:3];

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        k12a_gpio_port #(
            .DATA_W      (DATA_W),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clock    (clock),
            .reset    (reset),
            .sel      (port_idx == PORT_W'(p)),
            .load     (load),
            .store    (store),
            .reg_addr (io.io_addr[2:0]),
            .wr_dat   (data_bus),
            .pin_in   (gpio_in[p*DATA_W +: DATA_W]),
            .rd_dat   (rd_dat[p]),
            .rd_vld   (rd_vld[p]),
            .out_dat  (gpio_out[p*DATA_W +: DATA_W]),
            .oe_dat   (gpio_oe[p*DATA_W +: DATA_W]),
            .pend_dat (pend_dat[p])
        );
    end

    always_comb begin
        rd_any  = '0;
        any_vld = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (rd_vld[p]) begin
                rd_any = rd_any | rd_dat[p];
            end
            any_vld = any_vld | rd_vld[p];
        end
        wake = |pend_dat;
    end

    // A store strobe always owns the bus, even if a load is asserted alongside it.
    assign data_bus = (any_vld & ~store) ? rd_any : 'z;

endmodule

// File: tb/tb_k12a_gpio_bank.sv
// Directed bench for k12a_gpio_bank (3 ports x 8 bits, 2-stage sync) against a register-level model.
module tb_k12a_gpio_bank;

    localparam int NP = 3;
    localparam int SS = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] gpio_in = '0;
    logic [23:0] gpio_out, gpio_oe;
    logic        wake;
    logic [7:0]  tb_drv = '0;
    logic        tb_drv_en = 1'b0;
    logic        chk_on = 1'b0;
    tri1  [7:0]  data_bus;
    int          n_vec = 0;
    int          n_err = 0;

    k12a_gpio_bank_if #(.ADDR_W(5)) bus ();

    assign data_bus = tb_drv_en ? tb_drv : 8'hzz;

    k12a_gpio_bank #(.NUM_PORTS(NP), .DATA_W(8), .SYNC_STAGES(SS)) dut (
        .clock    (clock),
        .reset    (reset),
        .io       (bus),
        .data_bus (data_bus),
        .gpio_out (gpio_out),
        .gpio_oe  (gpio_oe),
        .gpio_in  (gpio_in),
        .wake     (wake)
    );

    always #5 clock = ~clock;

    // Model: register contents per port plus a history of pin samples, newest first.
    logic [7:0]  m_out [NP];
    logic [7:0]  m_dir [NP];
    logic [7:0]  m_ren [NP];
    logic [7:0]  m_fen [NP];
    logic [7:0]  m_pend[NP];
    logic [23:0] m_hist[SS+1];

    initial begin
        for (int p = 0; p < NP; p++) begin
            m_out[p] = '0; m_dir[p] = '0; m_ren[p] = '0; m_fen[p] = '0; m_pend[p] = '0;
        end
        for (int i = 0; i <= SS; i++) m_hist[i] = '0;
    end

    always @(posedge clock) begin : model
        logic [23:0] rise, fall;
        logic [7:0]  d, w1c;
        logic [2:0]  r;
        logic        wr_here;
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                m_out[p] = '0; m_dir[p] = '0; m_ren[p] = '0; m_fen[p] = '0; m_pend[p] = '0;
            end
            for (int i = 0; i <= SS; i++) m_hist[i] = '0;
        end else begin
            rise = m_hist[SS-1] & ~m_hist[SS];
            fall = ~m_hist[SS-1] & m_hist[SS];
            d    = tb_drv;
            r    = bus.io_addr[2:0];
            for (int p = 0; p < NP; p++) begin
                wr_here   = !bus.io_store_n && (int'(bus.io_addr[4:3]) == p);
                w1c       = (wr_here && r == 3'd5) ? d : 8'h00;
                m_pend[p] = (m_pend[p] & ~w1c) | (rise[p*8 +: 8] & m_ren[p]) | (fall[p*8 +: 8] & m_fen[p]);
                if (wr_here) begin
                    case (r)
                        3'd0: m_out[p] = d;
                        3'd1: m_dir[p] = d;
                        3'd3: m_ren[p] = d;
                        3'd4: m_fen[p] = d;
                        3'd6: m_out[p] = m_out[p] | d;
                        3'd7: m_out[p] = m_out[p] & ~d;
                        default: ;
                    endcase
                end
            end
            for (int i = SS; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = gpio_in;
        end
    end

    function automatic logic [7:0] m_reg(input int p, input logic [2:0] r);
        case (r)
            3'd0:    return m_out[p];
            3'd1:    return m_dir[p];
            3'd2:    return m_hist[SS-1][p*8 +: 8];
            3'd3:    return m_ren[p];
            3'd4:    return m_fen[p];
            3'd5:    return m_pend[p];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] exp_bus();
        if (!bus.io_store_n) return tb_drv;
        if (!bus.io_load_n && int'(bus.io_addr[4:3]) < NP) return m_reg(int'(bus.io_addr[4:3]), bus.io_addr[2:0]);
        return 8'hFF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (chk_on) begin
            logic [23:0] eo, ee;
            logic        ew;
            ew = 1'b0;
            for (int p = 0; p < NP; p++) begin
                eo[p*8 +: 8] = m_out[p];
                ee[p*8 +: 8] = m_dir[p];
                ew = ew | (m_pend[p] != 8'h00);
            end
            check("cmp_gpio_out", 32'(gpio_out), 32'(eo));
            check("cmp_gpio_oe",  32'(gpio_oe),  32'(ee));
            check("cmp_wake",     32'(wake),     32'(ew));
            check("cmp_bus",      32'(data_bus), 32'(exp_bus()));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        bus.io_load_n  = 1'b1;
        bus.io_store_n = 1'b1;
        tb_drv_en      = 1'b0;
    endtask

    task automatic wr(input logic [1:0] p, input logic [2:0] r, input logic [7:0] d);
        bus.io_addr    = {p, r};
        bus.io_store_n = 1'b0;
        tb_drv         = d;
        tb_drv_en      = 1'b1;
        tick();
        set_idle();
    endtask

    task automatic rd(input logic [1:0] p, input logic [2:0] r, input logic [7:0] exp, input string name);
        bus.io_addr   = {p, r};
        bus.io_load_n = 1'b0;
        #2;
        check(name, 32'(data_bus), 32'(exp));
        tick();
        set_idle();
    endtask

    initial begin
        bus.io_addr = '0;
        set_idle();
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_on = 1'b1;

        // Reset state
        check("rst_gpio_out", 32'(gpio_out), 32'h0);
        check("rst_gpio_oe",  32'(gpio_oe),  32'h0);
        check("rst_wake",     32'(wake),     32'h0);
        check("rst_bus_idle", 32'(data_bus), 32'hFF);
        for (int r = 0; r < 8; r++) rd(2'd0, 3'(r), 8'h00, "rst_reg");

        // OUT, SET, CLR on port 0
        wr(2'd0, 3'd0, 8'hA5);
        check("out_a5", 32'(gpio_out[7:0]), 32'hA5);
        rd(2'd0, 3'd0, 8'hA5, "rd_out_a5");
        wr(2'd0, 3'd6, 8'h0A);
        check("set_af", 32'(gpio_out[7:0]), 32'hAF);
        rd(2'd0, 3'd0, 8'hAF, "rd_out_af");
        wr(2'd0, 3'd7, 8'h81);
        check("clr_2e", 32'(gpio_out[7:0]), 32'h2E);
        rd(2'd0, 3'd0, 8'h2E, "rd_out_2e");
        rd(2'd0, 3'd6, 8'h00, "rd_set_zero");
        wr(2'd0, 3'd2, 8'hFF);
        rd(2'd0, 3'd2, 8'h00, "in_write_ignored");

        // DIR on port 2
        wr(2'd2, 3'd1, 8'h3C);
        check("oe_3c", 32'(gpio_oe), 32'h3C0000);
        rd(2'd2, 3'd1, 8'h3C, "rd_dir_3c");

        // Rising edge on port 1 bit 0
        wr(2'd1, 3'd3, 8'h01);
        gpio_in[8] = 1'b1;
        tick();
        rd(2'd1, 3'd2, 8'h00, "in_after_e1");
        check("wake_after_e2", 32'(wake), 32'h0);
        rd(2'd1, 3'd2, 8'h01, "in_after_e2");
        check("wake_after_e3", 32'(wake), 32'h1);
        rd(2'd1, 3'd5, 8'h01, "pend_rise");
        wr(2'd1, 3'd5, 8'h01);
        check("wake_cleared", 32'(wake), 32'h0);
        rd(2'd1, 3'd5, 8'h00, "pend_cleared");

        // Falling edge coincident with a W1C of the same bit
        wr(2'd1, 3'd4, 8'h01);
        gpio_in[8] = 1'b0;
        tick();
        tick();
        wr(2'd1, 3'd5, 8'h01);
        check("wake_set_wins", 32'(wake), 32'h1);
        rd(2'd1, 3'd5, 8'h01, "pend_set_wins");
        wr(2'd1, 3'd5, 8'h01);
        check("wake_w1c", 32'(wake), 32'h0);

        // Enable written in the same cycle as the edge: old (0) enable applies
        gpio_in[16] = 1'b1;
        tick();
        tick();
        wr(2'd2, 3'd3, 8'h01);
        check("late_en_wake", 32'(wake), 32'h0);
        rd(2'd2, 3'd5, 8'h00, "late_en_pend");
        rd(2'd2, 3'd3, 8'h01, "late_en_rd");

        // Nonexistent port 3
        wr(2'd3, 3'd0, 8'hFF);
        wr(2'd3, 3'd1, 8'hFF);
        check("bad_port_out", 32'(gpio_out), 32'h00002E);
        check("bad_port_oe",  32'(gpio_oe),  32'h3C0000);
        rd(2'd3, 3'd0, 8'hFF, "bad_port_rd_hiz");

        // Both strobes low: write happens, DUT leaves the bus alone
        bus.io_addr    = {2'd0, 3'd0};
        bus.io_load_n  = 1'b0;
        bus.io_store_n = 1'b0;
        tb_drv         = 8'h55;
        tb_drv_en      = 1'b1;
        #2;
        check("both_strobe_bus", 32'(data_bus), 32'h55);
        tick();
        set_idle();
        check("both_strobe_out", 32'(gpio_out[7:0]), 32'h55);

        // Reset while an edge is in the synchroniser
        wr(2'd0, 3'd3, 8'hFF);
        gpio_in[7:0] = 8'hFF;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_out",  32'(gpio_out), 32'h0);
        check("mid_rst_oe",   32'(gpio_oe),  32'h0);
        check("mid_rst_wake", 32'(wake),     32'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_rst_no_pend", 32'(wake), 32'h0);
        end
        rd(2'd0, 3'd2, 8'hFF, "mid_rst_in");
        rd(2'd0, 3'd5, 8'h00, "mid_rst_pend");
        rd(2'd0, 3'd3, 8'h00, "mid_rst_rise_en");

        tick();
        tick();
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
